// File: rtl/display_pkg.sv
// Shared display constants and the scan-arbiter state encoding.
//   H_ACTIVE / V_ACTIVE : visible frame size in pixels / lines
//   PIX_W               : packed pixel width {R[11:8], G[7:4], B[3:0]}
//   scan_state_e        : arbiter FSM states (IDLE=0, FLUSH=1, RUN=2)
package display_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned PIX_W    = 12;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFlush = 2'd1,
    StRun   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous prefetch FIFO for scan-out pixels.
//   clk, rst_ : clock, async active-low reset
//   clear     : synchronous flush (pointers and count to 0, push/pop ignored)
//   push/wdata: write one pixel (accepted when not full, or full with a pop)
//   pop       : drop the head pixel (ignored when empty)
//   rdata     : current head pixel (valid when !empty)
//   count, empty, full : occupancy status
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PIX_W = 12,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata,
  output logic [CntW-1:0]  count,
  output logic             empty,
  output logic             full
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Frame-buffer RAM arbiter: display scan-out prefetch vs. draw-engine writes.
//   clk, rst_          : clock (one RAM slot per cycle), async active-low reset
//   frame_start        : pulse before a frame; flushes FIFO/pipe, restarts at address 0
//   pix_pop            : colour stage consumes one pixel
//   pixel_out          : registered pixel (0 on underrun or frame_start)
//   underrun           : sticky, cleared by reset or frame_start
//   wr_req/addr/data   : draw write request, held until wr_gnt
//   wr_gnt             : high alongside the RAM write strobe it granted
//   mem_en/we/addr/wdata, mem_rdata : single-port RAM, read latency RD_LAT
// The slot decision is combinational; all mem_* outputs and wr_gnt are registered,
// so a read counts as issued in the cycle mem_en is visible.
module fb_scan_arbiter #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned PIX_W   = 12,
  parameter int unsigned FB_SIZE = 307200,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LOW_WM  = 3,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              underrun,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  import display_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned OccW = $clog2(DEPTH + RD_LAT + 1) + 1;

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  // busy_q tracks every outstanding RAM read; vld_q is the same pipe but wiped by
  // frame_start so stale returns are dropped while FLUSH still waits for the RAM.
  logic [RD_LAT:0]   busy_q, vld_q;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty, fifo_full, fifo_clear, fifo_pop;
  logic [PIX_W-1:0]  fifo_head;
  logic [OccW-1:0]   inflight, occ;
  logic              issue_rd, issue_wr, rd_allowed;

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= int'(RD_LAT); i++) begin
      inflight = inflight + OccW'(busy_q[i]);
    end
  end

  assign occ        = OccW'(fifo_count) + inflight;
  assign fifo_clear = frame_start || (state_q == StFlush);
  assign fifo_pop   = pix_pop && !frame_start;

  pixel_fifo #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_pixel_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .clear (fifo_clear),
    .push  (vld_q[RD_LAT]),
    .pop   (fifo_pop),
    .wdata (mem_rdata),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  ;
      StFlush: if (inflight == '0) state_d = StRun;
      StRun:   ;
      default: state_d = StIdle;
    endcase
    if (frame_start) state_d = StFlush;
  end

  // Slot decision: urgent read > write > opportunistic read > idle.
  // Reads are withheld on frame_start since their data would be discarded anyway.
  always_comb begin
    issue_rd   = 1'b0;
    issue_wr   = 1'b0;
    rd_allowed = (state_q == StRun) && !frame_start;
    if (rd_allowed && (occ < OccW'(LOW_WM))) begin
      issue_rd = 1'b1;
    end else if (wr_req) begin
      issue_wr = 1'b1;
    end else if (rd_allowed && (occ < OccW'(DEPTH)) && !fifo_full) begin
      issue_rd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      wr_gnt    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= issue_rd || issue_wr;
      mem_we <= issue_wr;
      wr_gnt <= issue_wr;
      if (issue_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (issue_rd) begin
        mem_addr  <= rd_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rd_addr_q <= '0;
      busy_q    <= '0;
      vld_q     <= '0;
    end else begin
      if (fifo_clear) begin
        rd_addr_q <= '0;
      end else if (issue_rd) begin
        rd_addr_q <= (rd_addr_q == ADDR_W'(FB_SIZE - 1)) ? '0 : rd_addr_q + 1'b1;
      end
      busy_q <= {busy_q[RD_LAT-1:0], issue_rd};
      vld_q  <= frame_start ? '0 : {vld_q[RD_LAT-1:0], issue_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      pixel_out <= '0;
      underrun  <= 1'b0;
    end else if (frame_start) begin
      underrun <= 1'b0;
      if (pix_pop) pixel_out <= '0;
    end else if (pix_pop) begin
      if (fifo_empty) begin
        pixel_out <= '0;
        underrun  <= 1'b1;
      end else begin
        pixel_out <= fifo_head;
      end
    end
  end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter. RAM model returns the address as data after
// two clocks; FB_SIZE is shrunk so the read-address wrap is reachable quickly.
module tb_fb_scan_arbiter;

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned FB_SIZE = 40;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned LOW_WM  = 3;
  localparam int unsigned RD_LAT  = 2;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_pop = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic [PIX_W-1:0]  pixel_out;
  logic              underrun;
  logic              wr_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic [PIX_W-1:0]  rd_stage = '0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned exp_rd = 0;
  int unsigned exp_pix = 0;

  always #5 clk = ~clk;

  fb_scan_arbiter #(
    .ADDR_W  (ADDR_W),
    .PIX_W   (PIX_W),
    .FB_SIZE (FB_SIZE),
    .DEPTH   (DEPTH),
    .LOW_WM  (LOW_WM),
    .RD_LAT  (RD_LAT)
  ) dut (
    .clk         (clk),
    .rst_        (rst_),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pixel_out   (pixel_out),
    .underrun    (underrun),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_gnt      (wr_gnt),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Two-stage RAM read model, data = address.
  always @(posedge clk) begin
    rd_stage  <= (mem_en && !mem_we) ? PIX_W'(mem_addr) : '0;
    mem_rdata <= rd_stage;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every issued read must follow the wrapping address sequence from 0.
  always @(negedge clk) begin
    #1;
    if (rst_ && mem_en && !mem_we) begin
      check("rd_addr_seq", 32'(mem_addr), 32'(exp_rd));
      exp_rd <= (exp_rd + 1) % FB_SIZE;
    end
    if (frame_start || !rst_) exp_rd <= 0;
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    pix_pop = 1'b1;
    cyc();
    pix_pop = 1'b0;
    check(tag, 32'(pixel_out), 32'(exp_pix));
    exp_pix = (exp_pix + 1) % FB_SIZE;
  endtask

  task automatic chk_outputs_zero(input string tag);
    check({tag, "_pixel_out"}, 32'(pixel_out), 32'd0);
    check({tag, "_underrun"},  32'(underrun),  32'd0);
    check({tag, "_wr_gnt"},    32'(wr_gnt),    32'd0);
    check({tag, "_mem_en"},    32'(mem_en),    32'd0);
    check({tag, "_mem_we"},    32'(mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    exp_pix = 0;
  endtask

  initial begin
    cyc(2);
    chk_outputs_zero("reset");
    rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("idle_no_read", 32'(mem_en), 32'd0);
    end

    // Frame start: one FLUSH cycle, then eight back-to-back reads 0..7.
    pulse_frame_start();
    cyc();
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("fill_read", 32'(mem_en && !mem_we), 32'd1);
      check("fill_addr", 32'(mem_addr), 32'(i));
    end
    cyc();
    check("fill_stop", 32'(mem_en), 32'd0);
    cyc(4);

    for (int i = 0; i < 6; i++) begin
      pop_chk("scan_pix");
      check("scan_underrun", 32'(underrun), 32'd0);
      cyc(3);
    end
    cyc(10);

    // Held write with a full FIFO: grant every cycle until occ drops below 3.
    wr_req  = 1'b1;
    wr_addr = ADDR_W'(100);
    wr_data = 12'hABC;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("wr_gnt_full", 32'(wr_gnt), 32'd1);
      check("wr_mem_we", 32'(mem_we), 32'd1);
    end
    check("wr_mem_addr", 32'(mem_addr), 32'd100);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hABC);
    for (int i = 0; i < 6; i++) begin
      pop_chk("wr_pop_pix");
      check("wr_gnt_draining", 32'(wr_gnt), 32'd1);
    end
    cyc();
    check("urgent_read", 32'(mem_en && !mem_we), 32'd1);
    check("urgent_no_gnt", 32'(wr_gnt), 32'd0);
    cyc();
    check("wr_after_urgent", 32'(wr_gnt), 32'd1);
    wr_req = 1'b0;
    cyc(10);

    // Pop through the FB_SIZE-1 -> 0 wrap.
    for (int i = 0; i < 32; i++) begin
      pop_chk("wrap_pix");
      cyc();
    end
    cyc(12);

    // Three quick pops leave two reads in flight, then frame_start with a pop.
    for (int i = 0; i < 3; i++) pop_chk("pre_flush_pix");
    frame_start = 1'b1;
    pix_pop     = 1'b1;
    cyc();
    frame_start = 1'b0;
    pix_pop     = 1'b0;
    exp_pix     = 0;
    check("fs_pop_pixel", 32'(pixel_out), 32'd0);
    check("fs_pop_underrun", 32'(underrun), 32'd0);
    check("fs_no_read", 32'(mem_en), 32'd0);
    pix_pop = 1'b1;
    cyc();
    pix_pop = 1'b0;
    check("empty_pop_pixel", 32'(pixel_out), 32'd0);
    check("empty_pop_underrun", 32'(underrun), 32'd1);
    check("flush_no_read_1", 32'(mem_en), 32'd0);
    cyc();
    check("flush_no_read_2", 32'(mem_en), 32'd0);
    cyc();
    check("flush_no_read_3", 32'(mem_en), 32'd0);
    cyc();
    check("run_first_read", 32'(mem_en && !mem_we), 32'd1);
    check("run_first_addr", 32'(mem_addr), 32'd0);
    cyc(12);
    pop_chk("flush_first_pix");
    check("underrun_sticky", 32'(underrun), 32'd1);
    pop_chk("flush_second_pix");

    pulse_frame_start();
    check("underrun_cleared", 32'(underrun), 32'd0);
    cyc(14);
    pop_chk("frame2_pix");
    pop_chk("frame2_pix");
    cyc();

    // Asynchronous reset between clock edges while reads are active.
    #2 rst_ = 1'b0;
    #1 chk_outputs_zero("async_rst");
    cyc(2);
    rst_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rst_idle_no_read", 32'(mem_en), 32'd0);
    end
    pulse_frame_start();
    cyc(16);
    pop_chk("post_rst_pix");
    check("post_rst_underrun", 32'(underrun), 32'd0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fb_scan_arbiter.md
# fb_scan_arbiter

Shares the single-port frame-buffer RAM between display scan-out and the graphics-engine write port. A small prefetch FIFO keeps the colour stage supplied with one 12-bit pixel per active pixel. Drawing writes are granted in the remaining memory slots. Sits between the frame-buffer RAM, the draw engine, and the colour stage's `current_pixel` input.

## Interface
Parameters:
- `ADDR_W`, 19: frame-buffer address width.
- `PIX_W`, 12: pixel width, {R[11:8], G[7:4], B[3:0]}.
- `FB_SIZE`, 307200: pixels per frame (640×480). The read address wraps at `FB_SIZE-1`.
- `DEPTH`, 8: prefetch FIFO depth, power of 2.
- `LOW_WM`, 3: urgency watermark.
- `RD_LAT`, 2: RAM read latency in clocks, from `mem_en` with `!mem_we` to `mem_rdata` valid.

Ports:
- `clk` in 1: system clock. One RAM access slot per cycle.
- `rst_` in 1: asynchronous reset, active low.
- `frame_start` in 1: one-cycle pulse before the first active pixel of a frame.
- `pix_pop` in 1: consume one pixel (h_active && v_active && pixel strobe).
- `pixel_out` out `PIX_W`: registered pixel to the colour stage.
- `underrun` out 1: sticky flag, set when a pop occurs with an empty FIFO.
- `wr_req` in 1: draw engine requests a write. Held until granted.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in `PIX_W`: write data.
- `wr_gnt` out 1: one-cycle pulse in the cycle the write is issued to RAM.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_wdata` out `PIX_W`: RAM write data.
- `mem_rdata` in `PIX_W`: RAM read data.

## Operation
- Reset values:
  - `pixel_out`=0, `underrun`=0, `wr_gnt`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Read address = 0, FIFO empty, in-flight count = 0, state IDLE.
- FSM states:
  - IDLE: no reads are issued. Writes are served. On `frame_start` → FLUSH.
  - FLUSH: the FIFO is emptied and the read address is set to 0. No new reads are issued, and returning read data is discarded. When the in-flight count = 0 → RUN. Writes are served.
  - RUN: normal arbitration. A `frame_start` in any state → FLUSH, restarting that state's actions.
- Occupancy: `occ` = FIFO count + in-flight reads. A read may issue only when `occ < DEPTH`.
- Slot priority in RUN, evaluated each cycle:
  1. Read if `occ < LOW_WM` (urgent).
  2. Write if `wr_req`.
  3. Read if `occ < DEPTH`.
  4. Idle (`mem_en`=0).
- Issued read: `mem_addr` = read address. The read address then increments, wrapping from `FB_SIZE-1` to 0.
- Issued write: `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, and `wr_gnt`=1 in the same cycle.
- Read return: data is pushed into the FIFO `RD_LAT` cycles after issue, via a shift register of valid bits. Valid bits set before a `frame_start` are cleared, so that data is discarded.
- Pop:
  - FIFO non-empty: `pixel_out` <= FIFO head.
  - FIFO empty: `pixel_out` <= 0 and `underrun` <= 1.
  - With no pop, `pixel_out` holds its value.
- `underrun` is cleared only by reset or `frame_start`.
- Simultaneous events:
  - `frame_start` with `pix_pop`: `frame_start` wins. `pixel_out` <= 0 and `underrun` is not set.
  - FIFO push and pop in the same cycle: both occur, count unchanged.
  - `frame_start` with a granted write: the write still issues.

## Timing
- `pix_pop` at cycle t → `pixel_out` valid at t+1.
- Read issue at t → FIFO push at t+`RD_LAT`.
- Fill after RUN entry: the FIFO holds `DEPTH` pixels after `DEPTH`+`RD_LAT` cycles, provided `wr_req`=0.
- `wr_gnt` is combinational with the slot decision, registered together with the `mem_*` outputs. No gap is needed between consecutive grants.
- Write starvation: a write waits at most `LOW_WM` cycles while the display is consuming ≤1 pixel per 2 clocks.

## Structure
- Shared package `display_pkg` holds:
  - `H_ACTIVE`=640, `V_ACTIVE`=480, `PIX_W`=12.
  - State encoding: IDLE=2'd0, FLUSH=2'd1, RUN=2'd2.
- Sub-module `pixel_fifo`: synchronous FIFO with `DEPTH`/`PIX_W` parameters and push/pop/count/empty/full, plus a synchronous `clear` input used by FLUSH.
- Arbiter, FSM, address counter and latency pipe live in `fb_scan_arbiter`.

## Test plan
- Reset then `frame_start`, RAM model filled with address as data, no writes. Required response:
  - Reads at addresses 0..7 in consecutive cycles.
  - Pops every 4 clocks return 0x000, 0x001, 0x002… with `underrun`=0.
- `wr_req` held constantly with FIFO full. Required response:
  - `wr_gnt` every cycle while `occ`=8.
  - Once pops drop `occ` below 3, a read preempts the write.
- Pop at address `FB_SIZE-1`. Required response: the next read address is 0, and `pixel_out` sequence is 0x...FF (address 307199 truncated), then 0x000.
- Pop on an empty FIFO before the first read return. Required response: `pixel_out`=0, `underrun`=1, held until the next `frame_start`.
- `frame_start` issued while 2 reads are in flight. Required response:
  - Both returns are dropped.
  - FLUSH lasts until the in-flight count = 0.
  - The first FIFO pixel after that is address 0.
- `rst_` asserted mid-RUN, asynchronously between clock edges. Required response: all outputs 0 immediately, state IDLE, and no reads until `frame_start`.
